ucode_fetch_dec: RTL and testbench
==================================

UCODE_FETCH_DEC -- requirements
Module: ucode_fetch_dec

Interface
REQ-001 SHALL have parameter IM_ADDR_WIDTH, default 8, instruction-memory address width.
REQ-002 SHALL have parameter HWL_SEL_WIDTH, default 2, hw-loop select width.
REQ-003 SHALL have parameter INSTR_WIDTH, default 24, instruction word width; fixed at 24 for this opcode map.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  start request; sampled in IDLE only.
REQ-007 SHALL have port start_addr_i  input  IM_ADDR_WIDTH  program entry address.
REQ-008 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse on END.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse on illegal opcode.
REQ-011 SHALL have port pc_i  input  IM_ADDR_WIDTH  current program counter from the PC/hw-loop unit.
REQ-012 SHALL have port pc_en_o  output  1  PC advance/loop-evaluate strobe.
REQ-013 SHALL have port pc_we_o  output  1  PC overwrite strobe.
REQ-014 SHALL have port pc_o  output  IM_ADDR_WIDTH  PC overwrite value.
REQ-015 SHALL have port hwl_we_o  output  1  hw-loop configuration strobe.
REQ-016 SHALL have port hwl_sel_o  output  HWL_SEL_WIDTH  loop register selected.
REQ-017 SHALL have port hwl_end_addr_o  output  IM_ADDR_WIDTH  loop end address.
REQ-018 SHALL have port hwl_iterations_o  output  8  loop iteration count.
REQ-019 SHALL have port im_req_o  output  1  instruction-memory read request.
REQ-020 SHALL have port im_addr_o  output  IM_ADDR_WIDTH  read address; SHALL equal pc_i combinationally.
REQ-021 SHALL have port im_rdata_i  input  INSTR_WIDTH  read data, valid exactly one cycle after im_req_o.
REQ-022 SHALL have port cmd_valid_o  output  1  datapath command valid.
REQ-023 SHALL have port cmd_o  output  21  datapath command payload, instr[20:0].
REQ-024 SHALL have port cmd_ready_i  input  1  datapath command accept.

Function
REQ-025 SHALL implement the FSM states IDLE, FETCH, EXEC, LCFG, WAIT and CMD.
REQ-026 IDLE with start_i=1 SHALL assert pc_we_o=1 with pc_o=start_addr_i and go to FETCH.
REQ-027 FETCH SHALL assert im_req_o=1 for one cycle and go to EXEC; EXEC SHALL decode a registered copy of im_rdata_i, with opcode = instr[23:21].
REQ-028 NOP (000) SHALL assert pc_en_o for one cycle and go to FETCH.
REQ-029 LOOP (001) SHALL assert pc_en_o, latch sel=instr[20:19], end=instr[15:8] and iter=instr[7:0], then go to LCFG.
REQ-030 LCFG SHALL assert hwl_we_o for one cycle with the latched fields and pc_en_o=0, then go to FETCH, so the loop start equals the LOOP address + 1.
REQ-031 JUMP (010) SHALL assert pc_we_o with pc_o=instr[IM_ADDR_WIDTH-1:0] and go to FETCH.
REQ-032 WAIT (011) SHALL load a 16-bit counter with instr[15:0] and go to WAIT.
REQ-033 WAIT state SHALL decrement the counter each cycle and, when the counter is 0, assert pc_en_o and go to FETCH; a count of N SHALL stall exactly N+1 cycles from EXEC to pc_en_o, and a count of 0 SHALL advance on the cycle after EXEC.
REQ-034 CMD (100) SHALL go to CMD state and drive cmd_valid_o=1 with cmd_o=instr[20:0].
REQ-035 CMD state SHALL hold cmd_valid_o and cmd_o stable until cmd_ready_i=1; in the handshake cycle it SHALL assert pc_en_o and go to FETCH.
REQ-036 END (111) SHALL pulse done_o, go to IDLE and assert no pc_en_o.
REQ-037 Opcodes 101 and 110 SHALL pulse err_o and go to IDLE with no PC or loop strobe.
REQ-038 At most one of pc_en_o, pc_we_o and hwl_we_o SHALL be high in any cycle.
REQ-039 start_i outside IDLE SHALL be ignored.
REQ-040 Every output SHALL be 0 whenever it is not being actively asserted per REQ-026 to REQ-037.

Reset
REQ-041 rst_ni=0 at a rising edge SHALL force IDLE, clear the wait counter and latched loop fields, and drive every output to 0 in the following cycle, including mid-WAIT and mid-CMD (cmd_valid_o SHALL drop without a handshake).
REQ-042 After reset, the block SHALL accept start_i on the first cycle with rst_ni=1.

Verification
REQ-043 start_i with start_addr_i=0x10, memory {NOP, END} -> pc_we_o with pc_o=0x10, then pc_en_o one cycle, then done_o pulse, busy_o low afterwards.
REQ-044 LOOP sel=1 end=0x05 iter=3 at address 0x02 -> pc_en_o, then hwl_we_o next cycle with hwl_sel_o=1, hwl_end_addr_o=0x05, hwl_iterations_o=3, with pc_i=0x03 during hwl_we_o.
REQ-045 WAIT count 4 -> pc_en_o exactly 5 cycles after EXEC; WAIT count 0 -> pc_en_o the next cycle.
REQ-046 CMD with cmd_ready_i low for 3 cycles -> cmd_valid_o and cmd_o stable for 4 cycles, pc_en_o only in the ready cycle.
REQ-047 Opcode 110 -> err_o pulse, IDLE, no strobes; JUMP to 0x20 -> pc_we_o with pc_o=0x20.
REQ-048 rst_ni low during WAIT count 100 -> all outputs 0 next cycle; start_i accepted immediately after rst_ni rises.

Source files
------------

// File: rtl/ucode_fetch_dec_if.sv
// ---------------------------------------------------------------------------
// ucode_fetch_dec_if
// Bus bundle between the microcode fetch/decode block and its two external
// partners: the instruction memory (request/address out, read data back one
// cycle later) and the datapath command channel (valid/payload out, ready
// back).
//
//   im_req_o     decoder -> memory   read request
//   im_addr_o    decoder -> memory   read address
//   im_rdata_i   memory  -> decoder  read data, one cycle after im_req_o
//   cmd_valid_o  decoder -> datapath command valid
//   cmd_o        decoder -> datapath command payload (21 bits)
//   cmd_ready_i  datapath -> decoder command accept
//
// modport master : the decoder side
// modport slave  : the memory / datapath side
// ---------------------------------------------------------------------------
interface ucode_fetch_dec_if #(
    parameter int IM_ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH   = 24
);
    logic                     im_req_o;
    logic [IM_ADDR_WIDTH-1:0] im_addr_o;
    logic [INSTR_WIDTH-1:0]   im_rdata_i;
    logic                     cmd_valid_o;
    logic [20:0]              cmd_o;
    logic                     cmd_ready_i;

    modport master (
        output im_req_o,
        output im_addr_o,
        input  im_rdata_i,
        output cmd_valid_o,
        output cmd_o,
        input  cmd_ready_i
    );

    modport slave (
        input  im_req_o,
        input  im_addr_o,
        output im_rdata_i,
        input  cmd_valid_o,
        input  cmd_o,
        output cmd_ready_i
    );
endinterface

// File: rtl/ucode_fetch_dec.sv
// ---------------------------------------------------------------------------
// ucode_fetch_dec
// Microcode sequencer front end: fetches 24-bit instructions from a
// synchronous instruction memory, decodes the 3-bit opcode and drives the
// PC / hardware-loop unit and the datapath command channel.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_i/start_addr_i start request and entry address (honoured in IDLE)
//   busy_o               high whenever the sequencer is not idle
//   done_o / err_o       one-cycle pulses on END / illegal opcode
//   pc_i                 current PC from the PC/hw-loop unit
//   pc_en_o              PC advance / loop-evaluate strobe
//   pc_we_o, pc_o        PC overwrite strobe and value
//   hwl_we_o, hwl_sel_o, hwl_end_addr_o, hwl_iterations_o
//                        hw-loop configuration strobe and fields
//   bus                  instruction memory + command channel (master side)
//
// Opcodes (instr[23:21]): 000 NOP, 001 LOOP, 010 JUMP, 011 WAIT, 100 CMD,
// 111 END, 101/110 illegal.
//
// Instruction timing: FETCH spends one cycle requesting the word and one
// cycle capturing the returned data into instr_q; EXEC then decodes instr_q.
// Strobes are decoded from registered state; only the start acceptance in
// IDLE and the command handshake in CMD also look at an input.
// ---------------------------------------------------------------------------
module ucode_fetch_dec #(
    parameter int IM_ADDR_WIDTH = 8,
    parameter int HWL_SEL_WIDTH = 2,
    parameter int INSTR_WIDTH   = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [IM_ADDR_WIDTH-1:0] start_addr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    input  logic [IM_ADDR_WIDTH-1:0] pc_i,
    output logic                     pc_en_o,
    output logic                     pc_we_o,
    output logic [IM_ADDR_WIDTH-1:0] pc_o,
    output logic                     hwl_we_o,
    output logic [HWL_SEL_WIDTH-1:0] hwl_sel_o,
    output logic [IM_ADDR_WIDTH-1:0] hwl_end_addr_o,
    output logic [7:0]               hwl_iterations_o,
    ucode_fetch_dec_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LCFG,
        S_WAIT,
        S_CMD
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOOP = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_WAIT = 3'b011;
    localparam logic [2:0] OP_CMD  = 3'b100;
    localparam logic [2:0] OP_END  = 3'b111;

    state_t                   state_q, state_d;
    logic                     fetch_wait_q, fetch_wait_d;  // 1 = data-capture cycle of FETCH
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [15:0]              wait_cnt_q, wait_cnt_d;
    logic [HWL_SEL_WIDTH-1:0] loop_sel_q, loop_sel_d;
    logic [IM_ADDR_WIDTH-1:0] loop_end_q, loop_end_d;
    logic [7:0]               loop_iter_q, loop_iter_d;

    logic                     pc_en;
    logic                     pc_we;
    logic [IM_ADDR_WIDTH-1:0] pc_val;
    logic                     hwl_we;
    logic                     done;
    logic                     err;
    logic                     im_req;
    logic                     cmd_valid;
    logic [2:0]               opcode;

    assign opcode = instr_q[23:21];

    always_comb begin
        state_d      = state_q;
        fetch_wait_d = fetch_wait_q;
        instr_d      = instr_q;
        wait_cnt_d   = wait_cnt_q;
        loop_sel_d   = loop_sel_q;
        loop_end_d   = loop_end_q;
        loop_iter_d  = loop_iter_q;
        pc_en        = 1'b0;
        pc_we        = 1'b0;
        pc_val       = '0;
        hwl_we       = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        im_req       = 1'b0;
        cmd_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_we        = 1'b1;
                    pc_val       = start_addr_i;
                    fetch_wait_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!fetch_wait_q) begin
                    im_req       = 1'b1;
                    fetch_wait_d = 1'b1;
                end else begin
                    // Memory data is valid now; keep a registered copy for EXEC.
                    instr_d      = bus.im_rdata_i;
                    fetch_wait_d = 1'b0;
                    state_d      = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_NOP: begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_LOOP: begin
                        // PC advances now so that pc_i already points at the
                        // loop body start while LCFG writes the loop registers.
                        pc_en       = 1'b1;
                        loop_sel_d  = HWL_SEL_WIDTH'(instr_q[20:19]);
                        loop_end_d  = IM_ADDR_WIDTH'(instr_q[15:8]);
                        loop_iter_d = instr_q[7:0];
                        state_d     = S_LCFG;
                    end
                    OP_JUMP: begin
                        pc_we   = 1'b1;
                        pc_val  = instr_q[IM_ADDR_WIDTH-1:0];
                        state_d = S_FETCH;
                    end
                    OP_WAIT: begin
                        wait_cnt_d = instr_q[15:0];
                        state_d    = S_WAIT;
                    end
                    OP_CMD: begin
                        state_d = S_CMD;
                    end
                    OP_END: begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end

            S_LCFG: begin
                hwl_we  = 1'b1;
                state_d = S_FETCH;
            end

            S_WAIT: begin
                // Count N spends N+1 cycles here; the advance comes on the
                // cycle the counter reads zero.
                if (wait_cnt_q == 16'd0) begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q - 16'd1;
                end
            end

            S_CMD: begin
                cmd_valid = 1'b1;
                if (bus.cmd_ready_i) begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            fetch_wait_q <= 1'b0;
            instr_q      <= '0;
            wait_cnt_q   <= '0;
            loop_sel_q   <= '0;
            loop_end_q   <= '0;
            loop_iter_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_wait_q <= fetch_wait_d;
            instr_q      <= instr_d;
            wait_cnt_q   <= wait_cnt_d;
            loop_sel_q   <= loop_sel_d;
            loop_end_q   <= loop_end_d;
            loop_iter_q  <= loop_iter_d;
        end
    end

    // Payload outputs are forced to zero outside their strobe so that idle
    // buses carry no stale values.
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = done;
    assign err_o            = err;
    assign pc_en_o          = pc_en;
    assign pc_we_o          = pc_we;
    assign pc_o             = pc_val;
    assign hwl_we_o         = hwl_we;
    assign hwl_sel_o        = hwl_we ? loop_sel_q  : '0;
    assign hwl_end_addr_o   = hwl_we ? loop_end_q  : '0;
    assign hwl_iterations_o = hwl_we ? loop_iter_q : '0;
    assign bus.im_req_o     = im_req;
    assign bus.im_addr_o    = im_req ? pc_i : '0;
    assign bus.cmd_valid_o  = cmd_valid;
    assign bus.cmd_o        = cmd_valid ? instr_q[20:0] : '0;

endmodule

// File: tb/tb_ucode_fetch_dec.sv
// ---------------------------------------------------------------------------
// tb_ucode_fetch_dec
// Drives programs through ucode_fetch_dec with a simple PC unit (load on
// pc_we_o, +1 on pc_en_o) and a one-cycle-latency instruction memory.
// Expected strobe events (kind, value, cycle) come from an instruction-level
// interpreter of the program held in the bench; the DUT's observed events are
// compared against that list one by one.
// ---------------------------------------------------------------------------
module tb_ucode_fetch_dec;

    localparam int K_PCWE  = 0;
    localparam int K_PCEN  = 1;
    localparam int K_HWL   = 2;
    localparam int K_IMREQ = 3;
    localparam int K_CMDV  = 4;
    localparam int K_DONE  = 5;
    localparam int K_ERR   = 6;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  start_addr_i;
    logic        busy_o, done_o, err_o;
    logic [7:0]  pc_i = 8'h00;
    logic        pc_en_o, pc_we_o;
    logic [7:0]  pc_o;
    logic        hwl_we_o;
    logic [1:0]  hwl_sel_o;
    logic [7:0]  hwl_end_addr_o;
    logic [7:0]  hwl_iterations_o;

    ucode_fetch_dec_if #(.IM_ADDR_WIDTH(8), .INSTR_WIDTH(24)) bus ();

    ucode_fetch_dec #(
        .IM_ADDR_WIDTH(8),
        .HWL_SEL_WIDTH(2),
        .INSTR_WIDTH  (24)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .start_addr_i    (start_addr_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .pc_i            (pc_i),
        .pc_en_o         (pc_en_o),
        .pc_we_o         (pc_we_o),
        .pc_o            (pc_o),
        .hwl_we_o        (hwl_we_o),
        .hwl_sel_o       (hwl_sel_o),
        .hwl_end_addr_o  (hwl_end_addr_o),
        .hwl_iterations_o(hwl_iterations_o),
        .bus             (bus.master)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    logic [23:0] mem [0:255];
    ev_t act_q[$];
    ev_t exp_q[$];
    int  cmd_delays[$];
    int  ready_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // PC unit: overwrite has priority, otherwise advance by one.
    always @(posedge clk_i) begin
        if (pc_we_o)      pc_i <= pc_o;
        else if (pc_en_o) pc_i <= pc_i + 8'd1;
    end

    // Synchronous instruction memory, data one cycle after the request.
    always @(posedge clk_i) begin
        if (bus.im_req_o) bus.im_rdata_i <= mem[bus.im_addr_o];
    end

    // Command acceptor: each command is accepted after the number of
    // not-ready cycles queued for it.
    initial begin
        int vcnt;
        int d_cur;
        vcnt = 0;
        d_cur = 0;
        bus.cmd_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (bus.cmd_valid_o) begin
                if (vcnt == 0) d_cur = (ready_q.size() > 0) ? ready_q.pop_front() : 0;
                bus.cmd_ready_i = (vcnt == d_cur);
                vcnt++;
            end else begin
                vcnt = 0;
                bus.cmd_ready_i = 1'b0;
            end
        end
    end

    // Event monitor plus the one-strobe-at-a-time rule.
    always @(negedge clk_i) begin
        if (mon_en) begin
            checks++;
            assert ((32'(pc_en_o) + 32'(pc_we_o) + 32'(hwl_we_o)) <= 32'd1)
            else begin
                failures++;
                $error("FAIL strobe_excl cyc=%0d observed en/we/hwl=%b%b%b expected at most one",
                       cyc, pc_en_o, pc_we_o, hwl_we_o);
            end
            if (pc_we_o)      act_q.push_back('{K_PCWE,  32'(pc_o), cyc});
            if (pc_en_o)      act_q.push_back('{K_PCEN,  32'(pc_i), cyc});
            if (hwl_we_o)     act_q.push_back('{K_HWL,   {6'd0, pc_i, hwl_sel_o, hwl_end_addr_o, hwl_iterations_o}, cyc});
            if (bus.im_req_o) act_q.push_back('{K_IMREQ, 32'(bus.im_addr_o), cyc});
            if (bus.cmd_valid_o) act_q.push_back('{K_CMDV, 32'(bus.cmd_o), cyc});
            if (done_o)       act_q.push_back('{K_DONE,  32'd0, cyc});
            if (err_o)        act_q.push_back('{K_ERR,   32'd0, cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({busy_o, done_o, err_o, pc_en_o, pc_we_o, pc_o, hwl_we_o, hwl_sel_o,
                    hwl_end_addr_o, hwl_iterations_o, bus.im_req_o, bus.im_addr_o,
                    bus.cmd_valid_o, bus.cmd_o});
    endfunction

    // Instruction-level interpreter: walks the program and lists, per
    // instruction, the strobes the sequencer must produce and in which cycle.
    // An instruction whose fetch request is in cycle t+1 is decoded in t+3.
    task automatic build_expected(input int c0, input logic [7:0] start);
        int          t;
        int          ci;
        logic [7:0]  pc;
        logic [23:0] ins;
        int          n;
        t  = c0;
        ci = 0;
        pc = start;
        exp_q.delete();
        exp_q.push_back('{K_PCWE, 32'(start), c0});
        for (int steps = 0; steps < 64; steps++) begin
            exp_q.push_back('{K_IMREQ, 32'(pc), t + 1});
            ins = mem[pc];
            case (ins[23:21])
                3'b000: begin
                    exp_q.push_back('{K_PCEN, 32'(pc), t + 3});
                    pc = pc + 8'd1;
                    t  = t + 3;
                end
                3'b001: begin
                    exp_q.push_back('{K_PCEN, 32'(pc), t + 3});
                    exp_q.push_back('{K_HWL, {6'd0, pc + 8'd1, ins[20:19], ins[15:8], ins[7:0]}, t + 4});
                    pc = pc + 8'd1;
                    t  = t + 4;
                end
                3'b010: begin
                    exp_q.push_back('{K_PCWE, 32'(ins[7:0]), t + 3});
                    pc = ins[7:0];
                    t  = t + 3;
                end
                3'b011: begin
                    n = int'(ins[15:0]);
                    exp_q.push_back('{K_PCEN, 32'(pc), t + 4 + n});
                    pc = pc + 8'd1;
                    t  = t + 4 + n;
                end
                3'b100: begin
                    n = (ci < cmd_delays.size()) ? cmd_delays[ci] : 0;
                    ci++;
                    for (int k = 0; k <= n; k++) begin
                        if (k == n) exp_q.push_back('{K_PCEN, 32'(pc), t + 4 + k});
                        exp_q.push_back('{K_CMDV, 32'(ins[20:0]), t + 4 + k});
                    end
                    pc = pc + 8'd1;
                    t  = t + 4 + n;
                end
                3'b111: begin
                    exp_q.push_back('{K_DONE, 32'd0, t + 3});
                    return;
                end
                default: begin
                    exp_q.push_back('{K_ERR, 32'd0, t + 3});
                    return;
                end
            endcase
        end
    endtask

    // Start a program (optionally releasing reset in the same cycle), poke a
    // stray start mid-run, wait for done/err and compare the event lists.
    task automatic run_prog(input logic [7:0] start, input bit release_rst, input string name);
        int c0;
        bit fin;
        int nmin;
        act_q.delete();
        ready_q = cmd_delays;
        mon_en = 1'b1;
        @(posedge clk_i);
        #1;
        if (release_rst) rst_ni = 1'b1;
        start_i      = 1'b1;
        start_addr_i = start;
        c0 = cyc;
        build_expected(c0, start);
        @(posedge clk_i);
        #1;
        start_i      = 1'b0;
        start_addr_i = 8'($urandom);
        @(negedge clk_i);
        check({name, "_busy_run"}, 64'(busy_o), 64'd1);
        @(posedge clk_i);
        #1;
        start_i      = 1'b1;
        start_addr_i = 8'hEE;
        @(posedge clk_i);
        #1;
        start_i      = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(negedge clk_i);
            if (done_o || err_o) fin = 1'b1;
        end
        check({name, "_finished"}, 64'(fin), 64'd1);
        @(negedge clk_i);
        check({name, "_busy_after"}, 64'(busy_o), 64'd0);
        #1;
        mon_en = 1'b0;
        check({name, "_ev_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("%s_ev%0d(kind,val,cyc)", name, i),
                  {8'(act_q[i].kind), act_q[i].val, 24'(act_q[i].cyc)},
                  {8'(exp_q[i].kind), exp_q[i].val, 24'(exp_q[i].cyc)});
        end
        $display("run %s start=%02h events=%0d expected=%0d", name, start, act_q.size(), exp_q.size());
    endtask

    // Start a program, let it run a while, then hold reset for two edges and
    // check that everything is quiet after the first one.
    task automatic reset_mid(input logic [7:0] start, input string name);
        @(posedge clk_i);
        #1;
        start_i      = 1'b1;
        start_addr_i = start;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check({name, "_outputs_zero"}, all_outputs(), 64'd0);
        $display("reset %s outputs=%h", name, all_outputs());
    endtask

    function automatic void clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 24'hC00000;
    endfunction

    task automatic gen_prog(output logic [7:0] start);
        logic [7:0] a;
        logic [7:0] tgt;
        int         n;
        int         last;
        clear_mem();
        cmd_delays.delete();
        start = 8'($urandom_range(0, 120));
        a = start;
        n = $urandom_range(2, 9);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0: begin mem[a] = {3'b000, 21'($urandom)}; a = a + 8'd1; end
                1: begin mem[a] = {3'b001, 21'($urandom)}; a = a + 8'd1; end
                2: begin
                    tgt = a + 8'd1 + 8'($urandom_range(0, 2));
                    mem[a] = {3'b010, 13'($urandom), tgt};
                    a = tgt;
                end
                3: begin mem[a] = {3'b011, 5'($urandom), 16'($urandom_range(0, 6))}; a = a + 8'd1; end
                default: begin
                    mem[a] = {3'b100, 21'($urandom)};
                    cmd_delays.push_back($urandom_range(0, 4));
                    a = a + 8'd1;
                end
            endcase
        end
        last = $urandom_range(0, 2);
        if (last == 0)      mem[a] = {3'b111, 21'($urandom)};
        else if (last == 1) mem[a] = {3'b101, 21'($urandom)};
        else                mem[a] = {3'b110, 21'($urandom)};
    endtask

    initial begin
        logic [7:0] st;
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        start_addr_i = 8'h00;
        clear_mem();
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_outputs", all_outputs(), 64'd0);
        $display("reset initial outputs=%h", all_outputs());

        // {NOP, END} at 0x10
        clear_mem();
        cmd_delays.delete();
        mem[8'h10] = 24'h000000;
        mem[8'h11] = 24'hE00000;
        run_prog(8'h10, 1'b0, "nop_end");

        // LOOP sel=1 end=0x05 iter=3 at 0x02
        clear_mem();
        mem[8'h02] = {3'b001, 2'b01, 3'b000, 8'h05, 8'h03};
        mem[8'h03] = 24'hE00000;
        run_prog(8'h02, 1'b0, "loop");

        // WAIT 4 then WAIT 0
        clear_mem();
        mem[8'h40] = {3'b011, 5'd0, 16'd4};
        mem[8'h41] = {3'b011, 5'd0, 16'd0};
        mem[8'h42] = 24'hE00000;
        run_prog(8'h40, 1'b0, "wait");

        // CMD held three cycles before ready
        clear_mem();
        mem[8'h50] = {3'b100, 21'h1ABCDE};
        mem[8'h51] = 24'hE00000;
        cmd_delays.push_back(3);
        run_prog(8'h50, 1'b0, "cmd");

        // JUMP to 0x20 which holds illegal opcode 110
        clear_mem();
        cmd_delays.delete();
        mem[8'h60] = {3'b010, 13'd0, 8'h20};
        mem[8'h20] = 24'hC12345;
        run_prog(8'h60, 1'b0, "jump_err");

        // Reset in the middle of WAIT 100; restart on the first released cycle
        clear_mem();
        mem[8'h70] = {3'b011, 5'd0, 16'd100};
        mem[8'h71] = 24'hE00000;
        mem[8'h30] = 24'hE00000;
        reset_mid(8'h70, "rst_wait");
        run_prog(8'h30, 1'b1, "after_rst_wait");

        // Reset while a command is waiting for ready
        clear_mem();
        mem[8'h70] = {3'b100, 21'h0F0F0F};
        mem[8'h71] = 24'hE00000;
        mem[8'h30] = {3'b000, 21'd0};
        mem[8'h31] = 24'hE00000;
        ready_q.delete();
        ready_q.push_back(1000);
        reset_mid(8'h70, "rst_cmd");
        run_prog(8'h30, 1'b1, "after_rst_cmd");

        // Random programs
        for (int r = 0; r < 25; r++) begin
            gen_prog(st);
            run_prog(st, 1'b0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
